// File: rtl/apu_pkg.sv
// Shared APU waveform-path types: ADSR phase encoding, envelope configuration
// payload and the saturating step helper used by the envelope datapath.
package apu_pkg;

    localparam int unsigned ADSR_GAIN_W = 16;
    localparam int unsigned ADSR_TIME_W = 32;
    localparam int unsigned SAT_W       = 64;

    typedef enum logic [2:0] {
        ADSR_IDLE    = 3'd0,
        ADSR_ATTACK  = 3'd1,
        ADSR_DECAY   = 3'd2,
        ADSR_SUSTAIN = 3'd3,
        ADSR_RELEASE = 3'd4
    } adsr_phase_t;

    typedef struct packed {
        logic [ADSR_GAIN_W-1:0] attack_step;
        logic [ADSR_GAIN_W-1:0] decay_step;
        logic [ADSR_GAIN_W-1:0] release_step;
        logic [ADSR_GAIN_W-1:0] attack_level;
        logic [ADSR_GAIN_W-1:0] sustain_level;
        logic [ADSR_TIME_W-1:0] sustain_time;
        logic                   hold_mode;
    } adsr_config_t;

    // Move cur one step toward limit without overshoot; a zero step lands on limit at once.
    function automatic logic [SAT_W-1:0] sat_step(
        input logic [SAT_W-1:0] cur,
        input logic [SAT_W-1:0] step,
        input logic [SAT_W-1:0] limit,
        input logic             up
    );
        logic [SAT_W:0] sum;
        sum = (SAT_W+1)'(cur) + (SAT_W+1)'(step);
        if (step == '0) begin
            sat_step = limit;
        end else if (up) begin
            sat_step = (sum >= (SAT_W+1)'(limit)) ? limit : sum[SAT_W-1:0];
        end else if ((cur <= limit) || ((cur - limit) <= step)) begin
            sat_step = limit;
        end else begin
            sat_step = cur - step;
        end
    endfunction

endpackage

// File: rtl/adsr_envelope_gen.sv
// ADSR envelope generator: tick-driven attack/decay/sustain/release gain ramp
// with shadowed configuration, click-free retrigger and hold-until-release mode.
module adsr_envelope_gen
    import apu_pkg::*;
#(
    parameter int unsigned GAIN_WIDTH = ADSR_GAIN_W,
    parameter int unsigned TIME_WIDTH = ADSR_TIME_W
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  enable_i,
    input  logic                  start_i,
    input  logic                  release_i,
    input  logic                  hold_mode_i,
    input  logic                  tick_i,
    input  logic [GAIN_WIDTH-1:0] attack_step_i,
    input  logic [GAIN_WIDTH-1:0] decay_step_i,
    input  logic [GAIN_WIDTH-1:0] release_step_i,
    input  logic [GAIN_WIDTH-1:0] attack_level_i,
    input  logic [GAIN_WIDTH-1:0] sustain_level_i,
    input  logic [TIME_WIDTH-1:0] sustain_time_i,
    output logic [GAIN_WIDTH-1:0] gain_o,
    output logic [2:0]            phase_o,
    output logic                  idle_o,
    output logic                  done_o
);

    adsr_phase_t           r_state,  w_state_nxt;
    logic [GAIN_WIDTH-1:0] r_gain,   w_gain_nxt;
    logic [TIME_WIDTH-1:0] r_cnt,    w_cnt_nxt;
    logic                  r_done,   w_done_nxt;
    logic                  r_idle,   w_idle_nxt;

    // Shadow configuration, captured only on start
    logic [GAIN_WIDTH-1:0] r_att_step, w_att_step_nxt;
    logic [GAIN_WIDTH-1:0] r_dec_step, w_dec_step_nxt;
    logic [GAIN_WIDTH-1:0] r_rel_step, w_rel_step_nxt;
    logic [GAIN_WIDTH-1:0] r_att_lvl,  w_att_lvl_nxt;
    logic [GAIN_WIDTH-1:0] r_sus_lvl,  w_sus_lvl_nxt;
    logic [TIME_WIDTH-1:0] r_sus_time, w_sus_time_nxt;
    logic                  r_hold,     w_hold_nxt;

    logic [GAIN_WIDTH-1:0] w_att_gain;
    logic [GAIN_WIDTH-1:0] w_dec_gain;
    logic [GAIN_WIDTH-1:0] w_rel_gain;
    logic                  w_releasable;

    // Candidate gains for one tick of each ramping phase
    assign w_att_gain = GAIN_WIDTH'(sat_step(SAT_W'(r_gain), SAT_W'(r_att_step),
                                             SAT_W'(r_att_lvl), 1'b1));
    assign w_dec_gain = (r_sus_lvl >= r_att_lvl) ? r_sus_lvl :
                        GAIN_WIDTH'(sat_step(SAT_W'(r_gain), SAT_W'(r_dec_step),
                                             SAT_W'(r_sus_lvl), 1'b0));
    assign w_rel_gain = GAIN_WIDTH'(sat_step(SAT_W'(r_gain), SAT_W'(r_rel_step),
                                             SAT_W'(0), 1'b0));

    assign w_releasable = (r_state == ADSR_ATTACK) || (r_state == ADSR_DECAY) ||
                          (r_state == ADSR_SUSTAIN);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= ADSR_IDLE;
            r_gain     <= '0;
            r_cnt      <= '0;
            r_done     <= 1'b0;
            r_idle     <= 1'b1;
            r_att_step <= '0;
            r_dec_step <= '0;
            r_rel_step <= '0;
            r_att_lvl  <= '0;
            r_sus_lvl  <= '0;
            r_sus_time <= '0;
            r_hold     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_gain     <= w_gain_nxt;
            r_cnt      <= w_cnt_nxt;
            r_done     <= w_done_nxt;
            r_idle     <= w_idle_nxt;
            r_att_step <= w_att_step_nxt;
            r_dec_step <= w_dec_step_nxt;
            r_rel_step <= w_rel_step_nxt;
            r_att_lvl  <= w_att_lvl_nxt;
            r_sus_lvl  <= w_sus_lvl_nxt;
            r_sus_time <= w_sus_time_nxt;
            r_hold     <= w_hold_nxt;
        end
    end

    // Control priority: disable, start, release, then tick-driven ramp
    always_comb begin
        w_state_nxt    = r_state;
        w_gain_nxt     = r_gain;
        w_cnt_nxt      = r_cnt;
        w_done_nxt     = 1'b0;
        w_att_step_nxt = r_att_step;
        w_dec_step_nxt = r_dec_step;
        w_rel_step_nxt = r_rel_step;
        w_att_lvl_nxt  = r_att_lvl;
        w_sus_lvl_nxt  = r_sus_lvl;
        w_sus_time_nxt = r_sus_time;
        w_hold_nxt     = r_hold;

        if (!enable_i) begin
            w_state_nxt = ADSR_IDLE;
            w_gain_nxt  = '0;
            w_cnt_nxt   = '0;
        end else if (start_i) begin
            // Gain deliberately kept so a retrigger ramps from where it is
            w_state_nxt    = ADSR_ATTACK;
            w_cnt_nxt      = '0;
            w_att_step_nxt = attack_step_i;
            w_dec_step_nxt = decay_step_i;
            w_rel_step_nxt = release_step_i;
            w_att_lvl_nxt  = attack_level_i;
            w_sus_lvl_nxt  = sustain_level_i;
            w_sus_time_nxt = sustain_time_i;
            w_hold_nxt     = hold_mode_i;
        end else if (release_i && w_releasable) begin
            w_state_nxt = ADSR_RELEASE;
        end else if (tick_i) begin
            case (r_state)
                ADSR_ATTACK: begin
                    w_gain_nxt = w_att_gain;
                    if (w_att_gain == r_att_lvl) begin
                        w_state_nxt = ADSR_DECAY;
                    end
                end
                ADSR_DECAY: begin
                    w_gain_nxt = w_dec_gain;
                    if (w_dec_gain == r_sus_lvl) begin
                        w_state_nxt = ADSR_SUSTAIN;
                        w_cnt_nxt   = '0;
                    end
                end
                ADSR_SUSTAIN: begin
                    w_gain_nxt = r_sus_lvl;
                    if (!r_hold) begin
                        if (r_cnt == r_sus_time) begin
                            w_state_nxt = ADSR_RELEASE;
                            w_cnt_nxt   = '0;
                        end else begin
                            w_cnt_nxt = r_cnt + TIME_WIDTH'(1);
                        end
                    end
                end
                ADSR_RELEASE: begin
                    w_gain_nxt = w_rel_gain;
                    if (w_rel_gain == '0) begin
                        w_state_nxt = ADSR_IDLE;
                        w_done_nxt  = 1'b1;
                    end
                end
                ADSR_IDLE: begin
                    w_gain_nxt = '0;
                end
                default: begin
                    w_state_nxt = ADSR_IDLE;
                    w_gain_nxt  = '0;
                end
            endcase
        end

        w_idle_nxt = (w_state_nxt == ADSR_IDLE);
    end

    assign gain_o  = r_gain;
    assign phase_o = r_state;
    assign idle_o  = r_idle;
    assign done_o  = r_done;

endmodule

// File: tb/tb_adsr_envelope_gen.sv
// Self-checking bench for adsr_envelope_gen: directed scenarios plus a
// randomized run, all compared against an arithmetic envelope model.
module tb_adsr_envelope_gen;
    import apu_pkg::*;

    logic        clk_i;
    logic        rst_i;
    logic        enable_i;
    logic        start_i;
    logic        release_i;
    logic        hold_mode_i;
    logic        tick_i;
    logic [15:0] attack_step_i;
    logic [15:0] decay_step_i;
    logic [15:0] release_step_i;
    logic [15:0] attack_level_i;
    logic [15:0] sustain_level_i;
    logic [31:0] sustain_time_i;
    logic [15:0] gain_o;
    logic [2:0]  phase_o;
    logic        idle_o;
    logic        done_o;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    adsr_phase_t m_state;
    longint      m_gain;
    longint      m_cnt;
    logic        m_idle;
    logic        m_done;
    longint      c_as, c_ds, c_rs, c_al, c_sl, c_time;
    logic        c_hold;

    adsr_envelope_gen dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .enable_i       (enable_i),
        .start_i        (start_i),
        .release_i      (release_i),
        .hold_mode_i    (hold_mode_i),
        .tick_i         (tick_i),
        .attack_step_i  (attack_step_i),
        .decay_step_i   (decay_step_i),
        .release_step_i (release_step_i),
        .attack_level_i (attack_level_i),
        .sustain_level_i(sustain_level_i),
        .sustain_time_i (sustain_time_i),
        .gain_o         (gain_o),
        .phase_o        (phase_o),
        .idle_o         (idle_o),
        .done_o         (done_o)
    );

    always #5 clk_i = ~clk_i;

    // Envelope rules applied to one clock cycle of inputs
    task automatic model_step(input logic rst, input logic en, input logic st,
                              input logic rl, input logic tk);
        longint nxt;
        m_done = 1'b0;
        if (rst) begin
            m_state = ADSR_IDLE; m_gain = 0; m_cnt = 0;
            c_as = 0; c_ds = 0; c_rs = 0; c_al = 0; c_sl = 0; c_time = 0; c_hold = 1'b0;
        end else if (!en) begin
            m_state = ADSR_IDLE; m_gain = 0;
        end else if (st) begin
            c_as = attack_step_i; c_ds = decay_step_i; c_rs = release_step_i;
            c_al = attack_level_i; c_sl = sustain_level_i; c_time = sustain_time_i;
            c_hold = hold_mode_i;
            m_cnt = 0;
            m_state = ADSR_ATTACK;
        end else if (rl && (m_state == ADSR_ATTACK || m_state == ADSR_DECAY ||
                            m_state == ADSR_SUSTAIN)) begin
            m_state = ADSR_RELEASE;
        end else if (tk) begin
            case (m_state)
                ADSR_ATTACK: begin
                    nxt = (c_as == 0) ? c_al : m_gain + c_as;
                    if (nxt > c_al) nxt = c_al;
                    m_gain = nxt;
                    if (m_gain == c_al) m_state = ADSR_DECAY;
                end
                ADSR_DECAY: begin
                    nxt = (c_sl >= c_al || c_ds == 0) ? c_sl : m_gain - c_ds;
                    if (nxt < c_sl) nxt = c_sl;
                    m_gain = nxt;
                    if (m_gain == c_sl) begin m_state = ADSR_SUSTAIN; m_cnt = 0; end
                end
                ADSR_SUSTAIN: begin
                    m_gain = c_sl;
                    if (!c_hold) begin
                        if (m_cnt == c_time) begin m_state = ADSR_RELEASE; m_cnt = 0; end
                        else m_cnt = m_cnt + 1;
                    end
                end
                ADSR_RELEASE: begin
                    nxt = (c_rs == 0) ? 0 : m_gain - c_rs;
                    if (nxt < 0) nxt = 0;
                    m_gain = nxt;
                    if (m_gain == 0) begin m_state = ADSR_IDLE; m_done = 1'b1; end
                end
                default: m_gain = 0;
            endcase
        end
        m_idle = (m_state == ADSR_IDLE);
    endtask

    task automatic cycle(input logic st, input logic rl, input logic tk);
        start_i = st; release_i = rl; tick_i = tk;
        model_step(rst_i, enable_i, st, rl, tk);
        @(posedge clk_i);
        #1;
        start_i = 1'b0; release_i = 1'b0; tick_i = 1'b0;
    endtask

    task automatic set_cfg(input logic [15:0] as, input logic [15:0] al, input logic [15:0] ds,
                           input logic [15:0] sl, input logic [31:0] tm, input logic [15:0] rs,
                           input logic hm);
        attack_step_i = as; attack_level_i = al; decay_step_i = ds;
        sustain_level_i = sl; sustain_time_i = tm; release_step_i = rs; hold_mode_i = hm;
    endtask

    task automatic test_reset();
        rst_i = 1'b1; enable_i = 1'b1;
        cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b1);
        checks++;
        if (gain_o !== 16'h0 || phase_o !== ADSR_IDLE || idle_o !== 1'b1 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL reset gain=%h phase=%0d idle=%b done=%b expected 0/0/1/0",
                     gain_o, phase_o, idle_o, done_o);
        end
        rst_i = 1'b0;
    endtask

    task automatic test_timed();
        int dones = 0;
        set_cfg(16'h1000, 16'h8000, 16'h0800, 16'h4000, 32'd4, 16'h2000, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            if (done_o === 1'b1) dones++;
            checks++;
            if (gain_o !== 16'(m_gain) || phase_o !== m_state || idle_o !== m_idle || done_o !== m_done) begin
                failures++;
                $display("FAIL timed t=%0d gain=%h/%h phase=%0d/%0d idle=%b/%b done=%b/%b", i,
                         gain_o, 16'(m_gain), phase_o, m_state, idle_o, m_idle, done_o, m_done);
            end
            if (i == 7 || i == 15 || i == 20 || i == 22) begin
                checks++;
                if ((i == 7  && (gain_o !== 16'h8000 || phase_o !== ADSR_DECAY)) ||
                    (i == 15 && (gain_o !== 16'h4000 || phase_o !== ADSR_SUSTAIN)) ||
                    (i == 20 && (gain_o !== 16'h4000 || phase_o !== ADSR_RELEASE)) ||
                    (i == 22 && (gain_o !== 16'h0000 || phase_o !== ADSR_IDLE || done_o !== 1'b1))) begin
                    failures++;
                    $display("FAIL timed_point t=%0d gain=%h phase=%0d done=%b", i, gain_o, phase_o, done_o);
                end
            end
        end
        checks++;
        if (dones != 1 || idle_o !== 1'b1) begin
            failures++;
            $display("FAIL timed_done pulses=%0d expected 1 idle=%b expected 1", dones, idle_o);
        end
    endtask

    task automatic test_saturation();
        set_cfg(16'hF000, 16'hFFFF, 16'h0100, 16'hFFFF, 32'd0, 16'hFFFF, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            checks++;
            if (gain_o !== 16'(m_gain) || phase_o !== m_state || idle_o !== m_idle || done_o !== m_done) begin
                failures++;
                $display("FAIL sat t=%0d gain=%h/%h phase=%0d/%0d idle=%b/%b done=%b/%b", i,
                         gain_o, 16'(m_gain), phase_o, m_state, idle_o, m_idle, done_o, m_done);
            end
            if (i == 0 || i == 1 || i == 4) begin
                checks++;
                if ((i == 0 && gain_o !== 16'hF000) || (i == 1 && gain_o !== 16'hFFFF) ||
                    (i == 4 && (gain_o !== 16'h0000 || done_o !== 1'b1))) begin
                    failures++;
                    $display("FAIL sat_point t=%0d gain=%h done=%b", i, gain_o, done_o);
                end
            end
        end
    endtask

    task automatic test_hold();
        set_cfg(16'h1000, 16'h8000, 16'h0800, 16'h4000, 32'd2, 16'h1000, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 120; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            checks++;
            if (gain_o !== 16'(m_gain) || phase_o !== m_state || idle_o !== m_idle || done_o !== m_done) begin
                failures++;
                $display("FAIL hold t=%0d gain=%h/%h phase=%0d/%0d idle=%b/%b done=%b/%b", i,
                         gain_o, 16'(m_gain), phase_o, m_state, idle_o, m_idle, done_o, m_done);
            end
        end
        checks++;
        if (phase_o !== ADSR_SUSTAIN || gain_o !== 16'h4000) begin
            failures++;
            $display("FAIL hold_stay phase=%0d gain=%h expected 3/4000", phase_o, gain_o);
        end
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if (phase_o !== ADSR_RELEASE || gain_o !== 16'h4000) begin
            failures++;
            $display("FAIL hold_release phase=%0d gain=%h expected 4/4000", phase_o, gain_o);
        end
        for (int i = 0; i < 6; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            checks++;
            if (gain_o !== 16'(m_gain) || phase_o !== m_state || idle_o !== m_idle || done_o !== m_done) begin
                failures++;
                $display("FAIL hold_ramp t=%0d gain=%h/%h phase=%0d/%0d done=%b/%b", i,
                         gain_o, 16'(m_gain), phase_o, m_state, done_o, m_done);
            end
        end
        checks++;
        if (idle_o !== 1'b1 || gain_o !== 16'h0) begin
            failures++;
            $display("FAIL hold_end idle=%b gain=%h expected 1/0000", idle_o, gain_o);
        end
    endtask

    task automatic test_retrigger();
        set_cfg(16'h1000, 16'h4000, 16'h1000, 16'h3000, 32'd0, 16'h1000, 1'b1);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0);
        checks++;
        if (phase_o !== ADSR_RELEASE || gain_o !== 16'h3000) begin
            failures++;
            $display("FAIL retrig_pre phase=%0d gain=%h expected 4/3000", phase_o, gain_o);
        end
        cycle(1'b1, 1'b0, 1'b0);
        checks++;
        if (phase_o !== ADSR_ATTACK || gain_o !== 16'h3000) begin
            failures++;
            $display("FAIL retrig_start phase=%0d gain=%h expected 1/3000", phase_o, gain_o);
        end
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (gain_o !== 16'h4000 || gain_o !== 16'(m_gain) || phase_o !== m_state) begin
            failures++;
            $display("FAIL retrig_tick gain=%h expected 4000 phase=%0d/%0d", gain_o, phase_o, m_state);
        end
        enable_i = 1'b0;
        cycle(1'b0, 1'b0, 1'b0);
        enable_i = 1'b1;
    endtask

    task automatic test_zero_steps();
        set_cfg(16'h0000, 16'h8000, 16'h0000, 16'h9000, 32'd1, 16'h0000, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (gain_o !== 16'h8000 || phase_o !== ADSR_DECAY) begin
            failures++;
            $display("FAIL zero_attack gain=%h phase=%0d expected 8000/2", gain_o, phase_o);
        end
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (gain_o !== 16'h9000 || phase_o !== ADSR_SUSTAIN) begin
            failures++;
            $display("FAIL zero_decay gain=%h phase=%0d expected 9000/3", gain_o, phase_o);
        end
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 1'b0, 1'b1);
            checks++;
            if (gain_o !== 16'(m_gain) || phase_o !== m_state || idle_o !== m_idle || done_o !== m_done) begin
                failures++;
                $display("FAIL zero_tail t=%0d gain=%h/%h phase=%0d/%0d done=%b/%b", i,
                         gain_o, 16'(m_gain), phase_o, m_state, done_o, m_done);
            end
        end
    endtask

    task automatic test_priority();
        set_cfg(16'h1000, 16'h8000, 16'h0800, 16'h4000, 32'd4, 16'h2000, 1'b0);
        cycle(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 1'b1);
        enable_i = 1'b0;
        cycle(1'b0, 1'b0, 1'b1);
        checks++;
        if (gain_o !== 16'h0 || phase_o !== ADSR_IDLE || idle_o !== 1'b1 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL disable gain=%h phase=%0d idle=%b done=%b expected 0/0/1/0",
                     gain_o, phase_o, idle_o, done_o);
        end
        enable_i = 1'b1;
        cycle(1'b1, 1'b1, 1'b0);
        checks++;
        if (phase_o !== ADSR_ATTACK) begin
            failures++;
            $display("FAIL start_vs_release phase=%0d expected 1", phase_o);
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 1'b0);
            checks++;
            if (gain_o !== 16'h3000 || phase_o !== ADSR_ATTACK) begin
                failures++;
                $display("FAIL freeze t=%0d gain=%h phase=%0d expected 3000/1", i, gain_o, phase_o);
            end
        end
        rst_i = 1'b1;
        cycle(1'b0, 1'b0, 1'b1);
        rst_i = 1'b0;
        checks++;
        if (gain_o !== 16'h0 || phase_o !== ADSR_IDLE || idle_o !== 1'b1 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset gain=%h phase=%0d idle=%b done=%b expected 0/0/1/0",
                     gain_o, phase_o, idle_o, done_o);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 3000; i++) begin
            logic st, rl, tk;
            if ($urandom_range(0, 9) == 0) begin
                set_cfg(($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h2000)),
                        16'($urandom),
                        ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h2000)),
                        16'($urandom), 32'($urandom_range(0, 5)),
                        ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom_range(1, 16'h2000)),
                        ($urandom_range(0, 3) == 0));
            end
            enable_i = ($urandom_range(0, 99) != 0);
            rst_i    = ($urandom_range(0, 499) == 0);
            st = ($urandom_range(0, 49) == 0);
            rl = ($urandom_range(0, 39) == 0);
            tk = ($urandom_range(0, 3) != 0);
            cycle(st, rl, tk);
            checks++;
            if (gain_o !== 16'(m_gain) || phase_o !== m_state || idle_o !== m_idle || done_o !== m_done) begin
                failures++;
                $display("FAIL random t=%0d gain=%h/%h phase=%0d/%0d idle=%b/%b done=%b/%b", i,
                         gain_o, 16'(m_gain), phase_o, m_state, idle_o, m_idle, done_o, m_done);
            end
        end
        rst_i = 1'b0;
        enable_i = 1'b1;
    endtask

    initial begin
        clk_i = 1'b0;
        rst_i = 1'b1; enable_i = 1'b1; start_i = 1'b0; release_i = 1'b0; tick_i = 1'b0;
        set_cfg(16'h0, 16'h0, 16'h0, 16'h0, 32'd0, 16'h0, 1'b0);
        m_state = ADSR_IDLE; m_gain = 0; m_cnt = 0; m_idle = 1'b1; m_done = 1'b0;
        c_as = 0; c_ds = 0; c_rs = 0; c_al = 0; c_sl = 0; c_time = 0; c_hold = 1'b0;
        #2;
        test_reset();
        test_timed();
        test_saturation();
        test_hold();
        test_retrigger();
        test_zero_steps();
        test_priority();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/adsr_envelope_gen.md
Name: adsr_envelope_gen

Overview:
Parametrised ADSR envelope generator for the APU waveform synth path. It generalises the fixed 16-bit envelope with configurable gain and time widths and an update-tick input. It adds a hold-until-release gate mode, click-free retrigger, zero-step instant jumps and early release. Its gain output feeds the wave multiplier ahead of the mixer; its configuration comes from the WAVE_* registers.

Parameters:
GAIN_WIDTH, 16, width of gain levels and steps
TIME_WIDTH, 32, width of sustain duration counter (in ticks)

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
enable_i  in  1  ADSR enable; low forces IDLE, gain 0
start_i  in  1  single-cycle start/retrigger pulse
release_i  in  1  single-cycle pulse forcing RELEASE
hold_mode_i  in  1  0: timed sustain; 1: sustain until release_i
tick_i  in  1  envelope update strobe (sample rate)
attack_step_i  in  GAIN_WIDTH  gain increment per tick in ATTACK
decay_step_i  in  GAIN_WIDTH  gain decrement per tick in DECAY
release_step_i  in  GAIN_WIDTH  gain decrement per tick in RELEASE
attack_level_i  in  GAIN_WIDTH  attack peak
sustain_level_i  in  GAIN_WIDTH  sustain plateau
sustain_time_i  in  TIME_WIDTH  sustain duration in ticks (timed mode)
gain_o  out  GAIN_WIDTH  current envelope gain
phase_o  out  3  current state (adsr_phase_t)
idle_o  out  1  high in IDLE
done_o  out  1  one-cycle pulse on RELEASE->IDLE

Behaviour:
- Reset: state IDLE, gain_o 0, phase_o IDLE, idle_o 1, done_o 0, shadow config 0, sustain counter 0.
- All outputs registered; every effect appears the cycle after the causing input.
- Priority per cycle: rst_i > !enable_i > start_i > release_i > tick_i.
- !enable_i: state IDLE, gain 0, no done_o.
- start_i (any state, enable_i high):
  - latch all step/level/time/mode inputs into shadow registers; state ATTACK.
  - gain is NOT reset: retrigger continues from the current gain (no click).
- release_i: in ATTACK/DECAY/SUSTAIN -> RELEASE from current gain; ignored in IDLE/RELEASE.
- Only on tick_i (otherwise hold state and gain):
  - ATTACK: gain = min(gain + attack_step, attack_level), computed in GAIN_WIDTH+1 bits so no wrap.
    - At attack_level -> DECAY.
    - attack_step 0 jumps straight to attack_level.
    - If gain already >= attack_level on entry, clamp to attack_level and -> DECAY.
  - DECAY: gain = max(gain - decay_step, sustain_level), no underflow.
    - At sustain_level -> SUSTAIN.
    - Step 0 = instant.
    - sustain_level >= attack_level: gain set to sustain_level, -> SUSTAIN the same tick.
  - SUSTAIN: gain = sustain_level.
    - Timed mode: counter increments per tick; -> RELEASE on the tick where counter == sustain_time, counter cleared. sustain_time 0 leaves on the first tick.
    - Hold mode: stay until release_i.
  - RELEASE: gain = max(gain - release_step, 0); at 0 -> IDLE and done_o pulses 1 cycle. Step 0 = instant.
  - IDLE: gain 0.
- Sustain counter clears on entry to SUSTAIN and on start_i.
- start_i and release_i in the same cycle: start wins.
- Input changes after start_i have no effect until the next start_i.

Decomposition:
- apu_pkg gains:
  - adsr_phase_t (3-bit enum: ADSR_IDLE, ADSR_ATTACK, ADSR_DECAY, ADSR_SUSTAIN, ADSR_RELEASE)
  - adsr_config_t (packed struct of steps, levels, time, hold_mode; widths from package localparams with default 16/32).
- One FSM+datapath module; no sub-module required. A saturating add/sub helper function lives in the package.

Test Plan:
- Timed envelope: attack_step 0x1000, attack_level 0x8000, decay_step 0x0800, sustain 0x4000, time 4, release_step 0x2000, tick every cycle, start -> gain 0x1000..0x8000 in 8 ticks, 0x4000 after 8 more, held 4 ticks, 0 after 2 ticks, done_o one pulse, idle_o 1.
- Saturation: attack_step 0xF000, attack_level 0xFFFF -> gain 0xF000 then 0xFFFF (no wrap); release_step 0xFFFF -> 0 in one tick.
- Hold mode: hold_mode 1, sustain_time 2 -> stays SUSTAIN for 100 ticks; release_i -> RELEASE next cycle, ramps to 0.
- Retrigger: start_i in RELEASE at gain 0x3000 -> ATTACK, next tick gain 0x4000 (step 0x1000), not 0x1000.
- Zero steps / degenerate levels: all steps 0, sustain_level 0x9000 > attack_level 0x8000 -> ATTACK->0x8000, DECAY->0x9000 in single ticks.
- Control priority: enable_i low mid-DECAY -> gain 0, IDLE, no done_o; start_i+release_i same cycle -> ATTACK; tick_i held low -> gain frozen; rst_i mid-ATTACK -> all reset values next cycle.
